// File: rtl/fp_pkg.sv
// Shared single-precision constants, FSM states and flag indices for the floating ALU units.
// Flag indices are used only when FDIV_FLAGS_EN is defined.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int WORD_W = EXP_W + MAN_W + 1;
  localparam int BIAS   = 127;
  // Quotient bits: hidden + fraction + guard + round
  localparam int Q_W    = MAN_W + 3;

  localparam logic [WORD_W-1:0] QNAN     = 32'h7FC0_0000;
  localparam logic [WORD_W-1:0] POS_INF  = 32'h7F80_0000;
  localparam logic [WORD_W-1:0] POS_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, DIV, RND} state_t;

  localparam int FLG_W         = 5;
  localparam int FLG_INVALID   = 4;
  localparam int FLG_DIVBYZERO = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

endpackage

// File: rtl/floating_div_seq_if.sv
// Start/done handshake bundle for the sequential divider.
// The flags vector exists only when FDIV_FLAGS_EN is defined.
interface floating_div_seq_if;

  logic                      start;
  logic [fp_pkg::WORD_W-1:0] A;
  logic [fp_pkg::WORD_W-1:0] B;
  logic                      busy;
  logic                      done;
  logic [fp_pkg::WORD_W-1:0] result;
`ifdef FDIV_FLAGS_EN
  logic [fp_pkg::FLG_W-1:0]  flags;
`endif

  modport master (
    output start, A, B,
    input  busy, done, result
`ifdef FDIV_FLAGS_EN
    , input flags
`endif
  );

  modport slave (
    input  start, A, B,
    output busy, done, result
`ifdef FDIV_FLAGS_EN
    , output flags
`endif
  );

endinterface

// File: rtl/fp_round_rne.sv
// Combinational normalize / round-to-nearest-even / pack for a 26-bit quotient with sticky.
// Exception outputs (ovf, unf, inexact) exist only when FDIV_FLAGS_EN is defined.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic                    sign,
  input  logic signed [EXP_W+1:0] exp_in,
  input  logic [Q_W-1:0]          quo,
  input  logic                    sticky,
  output logic [WORD_W-1:0]       result
`ifdef FDIV_FLAGS_EN
  , output logic                  ovf
  , output logic                  unf
  , output logic                  inexact
`endif
);

  localparam logic signed [EXP_W+1:0] ONE   = (EXP_W+2)'(1);
  localparam logic signed [EXP_W+1:0] EZERO = '0;
  localparam logic signed [EXP_W+1:0] EMAX  = (EXP_W+2)'((1 << EXP_W) - 1);

  logic [Q_W-1:0]          norm;
  logic [MAN_W:0]          mant;
  logic                    guard;
  logic                    rs;
  logic                    up;
  logic [MAN_W+1:0]        sum;
  logic [MAN_W-1:0]        frac;
  logic signed [EXP_W+1:0] exp_adj;

  always_comb begin
    norm    = quo[Q_W-1] ? quo : {quo[Q_W-2:0], 1'b0};
    mant    = norm[Q_W-1:2];
    guard   = norm[1];
    // After a left shift there is no computed round bit; the remainder stands in for it
    rs      = norm[0] | sticky;
    up      = guard & (rs | mant[0]);
    sum     = {1'b0, mant} + {{(MAN_W+1){1'b0}}, up};
    frac    = sum[MAN_W+1] ? sum[MAN_W:1] : sum[MAN_W-1:0];
    exp_adj = exp_in;
    if (!quo[Q_W-1]) exp_adj = exp_adj - ONE;
    if (sum[MAN_W+1]) exp_adj = exp_adj + ONE;

    if (exp_adj >= EMAX)
      result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (exp_adj <= EZERO)
      result = {sign, {(EXP_W+MAN_W){1'b0}}};
    else
      result = {sign, exp_adj[EXP_W-1:0], frac};
  end

`ifdef FDIV_FLAGS_EN
  always_comb begin
    ovf     = (exp_adj >= EMAX);
    unf     = (exp_adj <= EZERO);
    inexact = guard | rs | ovf | unf;
  end
`endif

endmodule

// File: rtl/floating_div_seq.sv
// Sequential binary32 divider: restoring radix-2, one quotient bit per enabled clock, then round.
// Define FDIV_FLAGS_EN to add the {invalid, divbyzero, overflow, underflow, inexact} flags output.
module floating_div_seq
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  floating_div_seq_if.slave bus
);

  localparam logic [4:0]              LAST_ITER = 5'(Q_W - 1);
  localparam logic signed [EXP_W+1:0] BIAS_S    = (EXP_W+2)'(BIAS);

  state_t                  state;
  logic [4:0]              cnt;
  logic                    busy;
  logic                    done;
  logic [WORD_W-1:0]       result;

  logic                    sign;
  logic signed [EXP_W+1:0] exp_q;
  logic [MAN_W+1:0]        rem;
  logic [MAN_W:0]          dvs;
  logic [Q_W-1:0]          quo;
  logic                    is_special;
  logic [WORD_W-1:0]       special_res;
  logic [WORD_W-1:0]       rnd_res;

  logic [EXP_W-1:0]        ea, eb;
  logic                    s_in;
  logic                    a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic                    spec_hit;
  logic [WORD_W-1:0]       spec_val;
  logic [MAN_W+2:0]        diff;
  logic                    qbit;
  logic [MAN_W+1:0]        rem_sel;

`ifdef FDIV_FLAGS_EN
  logic [FLG_W-1:0]        flags;
  logic [FLG_W-1:0]        special_flags;
  logic [FLG_W-1:0]        spec_flags;
  logic                    rnd_ovf, rnd_unf, rnd_inexact;
`endif

  // Operand classification; denormals count as zero
  always_comb begin
    ea       = bus.A[WORD_W-2 -: EXP_W];
    eb       = bus.B[WORD_W-2 -: EXP_W];
    s_in     = bus.A[WORD_W-1] ^ bus.B[WORD_W-1];
    a_zero   = (ea == '0);
    b_zero   = (eb == '0);
    a_inf    = (ea == '1) && (bus.A[MAN_W-1:0] == '0);
    b_inf    = (eb == '1) && (bus.B[MAN_W-1:0] == '0);
    a_nan    = (ea == '1) && (bus.A[MAN_W-1:0] != '0);
    b_nan    = (eb == '1) && (bus.B[MAN_W-1:0] != '0);
    spec_hit = 1'b1;
    spec_val = QNAN;
`ifdef FDIV_FLAGS_EN
    spec_flags = '0;
`endif
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
`ifdef FDIV_FLAGS_EN
      spec_flags[FLG_INVALID] = 1'b1;
`endif
    end else if (b_zero) begin
      spec_val = {s_in, POS_INF[WORD_W-2:0]};
`ifdef FDIV_FLAGS_EN
      spec_flags[FLG_DIVBYZERO] = !a_inf;
`endif
    end else if (a_inf) begin
      spec_val = {s_in, POS_INF[WORD_W-2:0]};
    end else if (a_zero || b_inf) begin
      spec_val = {s_in, POS_ZERO[WORD_W-2:0]};
    end else begin
      spec_hit = 1'b0;
    end
  end

  always_comb begin
    diff    = {1'b0, rem} - {2'b00, dvs};
    qbit    = ~diff[MAN_W+2];
    rem_sel = qbit ? diff[MAN_W+1:0] : rem;
  end

  fp_round_rne u_round (
    .sign    (sign),
    .exp_in  (exp_q),
    .quo     (quo),
    .sticky  (|rem),
    .result  (rnd_res)
`ifdef FDIV_FLAGS_EN
    , .ovf     (rnd_ovf)
    , .unf     (rnd_unf)
    , .inexact (rnd_inexact)
`endif
  );

  // Control: FSM, handshake and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= POS_ZERO;
`ifdef FDIV_FLAGS_EN
      flags  <= '0;
`endif
    end else if (EN) begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          busy  <= 1'b1;
          cnt   <= '0;
          state <= spec_hit ? RND : DIV;
`ifdef FDIV_FLAGS_EN
          flags <= '0;
`endif
        end
        DIV: begin
          cnt <= cnt + 5'd1;
          if (cnt == LAST_ITER) state <= RND;
        end
        RND: begin
          result <= is_special ? special_res : rnd_res;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
`ifdef FDIV_FLAGS_EN
          flags  <= is_special ? special_flags
                               : {2'b00, rnd_ovf, rnd_unf & ~rnd_ovf, rnd_inexact};
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: operand capture and one restoring step per DIV cycle
  always_ff @(posedge clk) begin
    if (EN) begin
      if (state == IDLE && bus.start) begin
        sign        <= s_in;
        exp_q       <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S;
        rem         <= {2'b01, bus.A[MAN_W-1:0]};
        dvs         <= {1'b1, bus.B[MAN_W-1:0]};
        quo         <= '0;
        is_special  <= spec_hit;
        special_res <= spec_val;
`ifdef FDIV_FLAGS_EN
        special_flags <= spec_flags;
`endif
      end else if (state == DIV) begin
        rem <= rem_sel << 1;
        quo <= {quo[Q_W-2:0], qbit};
      end
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result;
`ifdef FDIV_FLAGS_EN
  assign bus.flags  = flags;
`endif

endmodule
